// File: rtl/key_arbiter.sv
// Arbitrates four HID key slots into one WASD direction code, with hold-off preemption and a space-bar pause toggle.
// Latency: outputs update on the Clk edge where frame_tick=1 and are visible 1 Clk after that tick.
// Backpressure: none; state only advances on frame_tick and holds on all other edges.
module key_arbiter #(
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    output logic [7:0] keycode_out,
    output logic [1:0] owner,
    output logic       owner_valid,
    output logic       paused,
    output logic       change_pulse
);

    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_PAUSE = 8'h2C;
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_PAUSED} state_t;

    state_t      state_q, state_d;
    logic [7:0]  prev_q [4];
    logic [7:0]  kc_q, kc_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  pend_q, pend_d;
    logic [7:0]  hold_q, hold_d;
    logic        change_q, change_d;

    logic [7:0]  slot [4];
    logic [3:0]  dir;
    logic [3:0]  new_press;
    logic [3:0]  pend_upd;
    logic        pause_now, pause_prev;
    logic [1:0]  first_dir, first_pend;

    assign slot[0] = keycode0;
    assign slot[1] = keycode1;
    assign slot[2] = keycode2;
    assign slot[3] = keycode3;

    // Per-slot decode: direction codes, new presses, pause edge, and lowest-index picks.
    always_comb begin
        pause_now  = 1'b0;
        pause_prev = 1'b0;
        dir        = '0;
        new_press  = '0;
        first_dir  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            dir[i]       = (slot[i] == KC_W) || (slot[i] == KC_S) ||
                           (slot[i] == KC_A) || (slot[i] == KC_D);
            new_press[i] = dir[i] && (slot[i] != prev_q[i]);
            pause_now    = pause_now  || (slot[i]   == KC_PAUSE);
            pause_prev   = pause_prev || (prev_q[i] == KC_PAUSE);
        end
        // Pending bits only accumulate for non-owner slots and drop when the key leaves.
        pend_upd = (pend_q | (new_press & ~(4'b0001 << owner_q))) & dir;
        first_pend = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dir[i])      first_dir  = 2'(i);
            if (pend_upd[i]) first_pend = 2'(i);
        end
    end

    // Next-state and output selection; everything holds unless frame_tick is high.
    always_comb begin
        state_d  = state_q;
        kc_d     = kc_q;
        owner_d  = owner_q;
        pend_d   = pend_q;
        hold_d   = hold_q;
        change_d = 1'b0;
        if (frame_tick) begin
            if (pause_now && !pause_prev) begin
                // Pause toggle overrides any direction activity on this tick.
                state_d = (state_q == S_PAUSED) ? S_IDLE : S_PAUSED;
                kc_d    = 8'h00;
                pend_d  = '0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_OWN: begin
                        if (state_q == S_OWN && slot[owner_q] == kc_q) begin
                            if (hold_q == 8'h00 && pend_upd != 4'b0000) begin
                                owner_d = first_pend;
                                kc_d    = slot[first_pend];
                                hold_d  = HOLD_LD;
                                pend_d  = '0;
                            end else begin
                                pend_d  = pend_upd;
                                hold_d  = (hold_q == 8'h00) ? 8'h00 : hold_q - 8'h01;
                            end
                        end else if (dir != 4'b0000) begin
                            // Fresh acquisition from IDLE, or owner released/changed.
                            state_d = S_OWN;
                            owner_d = first_dir;
                            kc_d    = slot[first_dir];
                            hold_d  = HOLD_LD;
                            pend_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                            kc_d    = 8'h00;
                            pend_d  = '0;
                        end
                    end
                    default: begin
                        kc_d = 8'h00;
                    end
                endcase
            end
            change_d = (kc_d != kc_q);
        end
    end

    // State registers with asynchronous clear; prev slots sample on every tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            kc_q     <= 8'h00;
            owner_q  <= 2'd0;
            pend_q   <= '0;
            hold_q   <= 8'h00;
            change_q <= 1'b0;
            for (int i = 0; i < 4; i++) prev_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            kc_q     <= kc_d;
            owner_q  <= owner_d;
            pend_q   <= pend_d;
            hold_q   <= hold_d;
            change_q <= change_d;
            if (frame_tick) begin
                for (int i = 0; i < 4; i++) prev_q[i] <= slot[i];
            end
        end
    end

    assign keycode_out  = kc_q;
    assign owner        = owner_q;
    assign owner_valid  = (state_q == S_OWN);
    assign paused       = (state_q == S_PAUSED);
    assign change_pulse = change_q;

endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter: expected outputs are queued as stimulus is driven and checked after each edge.
// Latency: each step drives inputs 1 time unit after a rising edge and checks 1 time unit after the next one.
// Backpressure: not applicable; the bench owns frame_tick.
module tb_key_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] keycode0, keycode1, keycode2, keycode3;
    logic [7:0] keycode_out;
    logic [1:0] owner;
    logic       owner_valid, paused, change_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] kc;
        logic [1:0] own;
        logic       ov;
        logic       ps;
        logic       cp;
    } exp_t;

    exp_t exp_q[$];

    key_arbiter #(.HOLD_FRAMES(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .keycode0    (keycode0),
        .keycode1    (keycode1),
        .keycode2    (keycode2),
        .keycode3    (keycode3),
        .keycode_out (keycode_out),
        .owner       (owner),
        .owner_valid (owner_valid),
        .paused      (paused),
        .change_pulse(change_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic push(input logic [7:0] kc, input logic [1:0] own,
                        input logic ov, input logic ps, input logic cp);
        exp_t e;
        e.kc = kc; e.own = own; e.ov = ov; e.ps = ps; e.cp = cp;
        exp_q.push_back(e);
    endtask

    // One Clk edge, with frame_tick held at t across it.
    task automatic step(input logic t);
        frame_tick = t;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty got nothing want entry", tag);
        end else begin
            e = exp_q.pop_front();
            checks++;
            assert (keycode_out === e.kc) else begin
                errors++; $error("FAIL %s keycode_out got %h want %h", tag, keycode_out, e.kc);
            end
            checks++;
            assert (owner === e.own) else begin
                errors++; $error("FAIL %s owner got %0d want %0d", tag, owner, e.own);
            end
            checks++;
            assert (owner_valid === e.ov) else begin
                errors++; $error("FAIL %s owner_valid got %b want %b", tag, owner_valid, e.ov);
            end
            checks++;
            assert (paused === e.ps) else begin
                errors++; $error("FAIL %s paused got %b want %b", tag, paused, e.ps);
            end
            checks++;
            assert (change_pulse === e.cp) else begin
                errors++; $error("FAIL %s change_pulse got %b want %b", tag, change_pulse, e.cp);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0;
        keycode0 = 8'h00; keycode1 = 8'h00; keycode2 = 8'h00; keycode3 = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        push(8'h00, 2'd0, 0, 0, 0); check("reset_state");
        Reset = 1'b0;

        // Basic acquire, then pulse drops on the following non-tick edge.
        keycode2 = 8'h07;
        push(8'h07, 2'd2, 1, 0, 1); step(1); check("acquire");
        push(8'h07, 2'd2, 1, 0, 0); step(0); check("acquire_pulse_end");

        // Release with nothing else held; owner keeps last index.
        keycode2 = 8'h00;
        push(8'h00, 2'd2, 0, 0, 1); step(1); check("release_idle");
        keycode0 = 8'h1A;
        push(8'h00, 2'd2, 0, 0, 0); step(0); check("no_tick_hold");
        keycode0 = 8'h00;
        push(8'h00, 2'd2, 0, 0, 0); step(1); check("idle_empty");

        // Simultaneous press: lowest index wins; release hands over same tick.
        keycode1 = 8'h1A; keycode3 = 8'h16;
        push(8'h1A, 2'd1, 1, 0, 1); step(1); check("simul_acquire");
        push(8'h1A, 2'd1, 1, 0, 0); step(1); check("simul_hold");
        keycode1 = 8'h00;
        push(8'h16, 2'd3, 1, 0, 1); step(1); check("simul_handover");
        keycode3 = 8'h00;
        push(8'h00, 2'd3, 0, 0, 1); step(1); check("simul_release");

        // Hold and preempt: acquire T0, press T1, transfer at T5; idle edges must not count.
        keycode0 = 8'h04;
        push(8'h04, 2'd0, 1, 0, 1); step(1); check("hold_T0");
        keycode1 = 8'h07;
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("hold_T1");
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("hold_T2");
        push(8'h04, 2'd0, 1, 0, 0); step(0); check("hold_gap1");
        push(8'h04, 2'd0, 1, 0, 0); step(0); check("hold_gap2");
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("hold_T3");
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("hold_T4");
        push(8'h07, 2'd1, 1, 0, 1); step(1); check("preempt_T5");

        // Pause toggle, held pause ignored, directions ignored while paused.
        keycode3 = 8'h2C;
        push(8'h00, 2'd1, 0, 1, 1); step(1); check("pause_on");
        push(8'h00, 2'd1, 0, 1, 0); step(1); check("pause_held");
        keycode3 = 8'h00;
        push(8'h00, 2'd1, 0, 1, 0); step(1); check("pause_key_up");
        keycode3 = 8'h2C;
        push(8'h00, 2'd1, 0, 0, 0); step(1); check("pause_off");
        push(8'h04, 2'd0, 1, 0, 1); step(1); check("pause_reacquire");

        // Back-to-back ticks: each cycle counts as a frame.
        keycode2 = 8'h16;
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("burst1");
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("burst2");
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("burst3");
        push(8'h04, 2'd0, 1, 0, 0); step(1); check("burst4");
        push(8'h16, 2'd2, 1, 0, 1); step(1); check("burst_preempt");

        // Async reset mid-cycle while owning; tick during reset ignored.
        #2 Reset = 1'b1;
        #1;
        push(8'h00, 2'd0, 0, 0, 0); check("async_reset_own");
        @(posedge Clk); #1;
        push(8'h00, 2'd0, 0, 0, 0); step(1); check("tick_in_reset");
        keycode3 = 8'h00;
        Reset = 1'b0;
        push(8'h04, 2'd0, 1, 0, 1); step(1); check("post_reset_acquire");
        keycode3 = 8'h2C;
        push(8'h00, 2'd0, 0, 1, 1); step(1); check("pause_before_reset");
        #2 Reset = 1'b1;
        #1;
        push(8'h00, 2'd0, 0, 0, 0); check("async_reset_paused");
        Reset = 1'b0;
        step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_arbiter.md
KEY_ARBITER -- requirements
Module: key_arbiter

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 4, giving the minimum number of frames an owner holds before preemption; legal range is 1..255.
REQ-002 SHALL have port Clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port frame_tick, input, 1 bit: a 1-Clk pulse marking one frame evaluation.
REQ-005 SHALL have ports keycode0, keycode1, keycode2, keycode3, each input, 8 bits: USB HID key slots, where 0x00 means empty.
REQ-006 SHALL have port keycode_out, output, 8 bits: the arbitrated direction code driven to the ball; 0x00 means no motion command.
REQ-007 SHALL have port owner, output, 2 bits: the index of the slot that owns keycode_out.
REQ-008 SHALL have port owner_valid, output, 1 bit: high while a slot owns keycode_out.
REQ-009 SHALL have port paused, output, 1 bit: the pause state.
REQ-010 SHALL have port change_pulse, output, 1 bit: a 1-Clk pulse when keycode_out changes value.

Function
REQ-011 SHALL treat only 0x1A (W), 0x16 (S), 0x04 (A) and 0x07 (D) as direction codes, 0x2C (space) as the pause code, and ignore all other codes.
REQ-012 SHALL update state and registered outputs only on Clk edges where frame_tick=1, with outputs visible 1 Clk after that tick; on all other edges it SHALL hold state.
REQ-013 SHALL sample each slot into a prev register on every tick; a new press SHALL mean the slot holds a direction code at this tick and held a different value at the previous tick.
REQ-014 SHALL implement states IDLE (no owner), OWN (owner latched) and PAUSED.
REQ-015 In IDLE, if any slot holds a direction code, SHALL latch the lowest such index as owner, set keycode_out to that code, set owner_valid=1, load hold_cnt=HOLD_FRAMES and go to OWN; otherwise it SHALL stay in IDLE with keycode_out=0x00.
REQ-016 In OWN, if the owner slot no longer equals keycode_out (released or changed), SHALL re-arbitrate as in REQ-015 on the same tick, and go to IDLE with keycode_out=0x00 and owner_valid=0 when no slot holds a direction code.
REQ-017 In OWN, a new press on a non-owner slot SHALL set that slot's pending bit; a pending bit SHALL clear when its slot no longer holds a direction code.
REQ-018 In OWN with the owner retained, if hold_cnt==0 (value before the tick) and the pending bits are nonzero, SHALL transfer ownership to the lowest pending index, load its code and reload hold_cnt; otherwise hold_cnt SHALL decrement, saturating at 0.
REQ-019 Any ownership change SHALL clear all pending bits.
REQ-020 With the above timing, the earliest preemption SHALL occur HOLD_FRAMES+1 ticks after acquisition.
REQ-021 A pause rising edge (any slot equals 0x2C at this tick and none did at the previous tick) SHALL toggle paused, taking precedence over all direction arbitration on that tick.
REQ-022 On entering PAUSED, SHALL force keycode_out=0x00, owner_valid=0 and clear pending; on leaving PAUSED, SHALL enter IDLE with outputs 0x00, so arbitration resumes on the next tick.
REQ-023 The owner output SHALL hold its last value when owner_valid=0.
REQ-024 change_pulse SHALL be high for exactly the 1 Clk following a tick in which keycode_out changed, and low otherwise.
REQ-025 frame_tick held high on consecutive Clk cycles SHALL count as one tick per cycle.
REQ-026 hold_cnt SHALL be 8 bits, and all comparisons SHALL be exact 8-bit equality.

Reset
REQ-027 While Reset=1, SHALL asynchronously force keycode_out=0x00, owner=0, owner_valid=0, paused=0, change_pulse=0, prev registers=0x00, pending=0, hold_cnt=0 and state IDLE.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately, without waiting for Clk, and frame_tick SHALL be ignored while Reset=1.
REQ-029 After Reset deasserts, the first frame_tick SHALL arbitrate from IDLE.

Verification
REQ-030 Basic acquire: keycode2=0x07, others 0x00, one tick -> next Clk keycode_out=0x07, owner=2, owner_valid=1, change_pulse=1 for 1 Clk.
REQ-031 Simultaneous press: keycode1=0x1A and keycode3=0x16 on the same tick -> owner=1, keycode_out=0x1A; release keycode1 at a later tick -> owner=3, keycode_out=0x16 on that tick.
REQ-032 Hold and preempt (HOLD_FRAMES=4): keycode0=0x04 acquired at tick T0, keycode1=0x07 pressed at T1 -> keycode_out stays 0x04 through T4, then becomes 0x07 with owner=1 at T5.
REQ-033 Pause: an owner is active and keycode3 goes 0x00->0x2C -> paused=1, keycode_out=0x00; keycode3 held at 0x2C -> no further toggle; keycode3 goes 0x00 then 0x2C again -> paused=0, and the next tick reacquires.
REQ-034 Release and no tick: owner released and no other key pressed -> keycode_out=0x00, owner_valid=0; key changes with frame_tick=0 -> no output change.
REQ-035 Async reset: Reset pulsed between Clk edges while OWN/paused -> all outputs zero before the next Clk edge; a tick during Reset has no effect.
